uart_tx_feeder: RTL and testbench

Byte buffer and launch controller directly upstream of the UART sender. It accepts single-cycle byte writes from the peripheral bus into a FIFO and presents bytes one at a time on `tx_data`. For each byte it raises `tx_en` and holds `tx_data` stable for the whole frame, using the sender's `tx_status` busy flag as the handshake. This removes the need for software to poll `tx_status` before every byte.

---
 rtl/uart_tx_feeder.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_feeder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO and launch controller in front of the UART sender.
// Bytes written on the bus are queued and handed to the sender one at a time,
// using the sender's busy flag as the handshake so software never has to poll.
//
// State table
//   SETTLE    | after reset, wait for a frame still in flight in the sender to end
//   IDLE      | pop the head byte into tx_data when the FIFO is not empty
//   LAUNCH    | raise tx_en, clear the busy timeout counter
//   WAIT_BUSY | hold tx_en until the sender reports busy, or give up on timeout
//   RETRY     | tx_en low before relaunching the same byte
//   WAIT_DONE | frame in progress, wait for the sender to go idle
//   GAP       | two low cycles so the sender sees tx_en low before the next launch
//
// Ports
//   uart_clk   clock shared with the sender
//   reset      asynchronous active-low reset
//   wr_data    byte to enqueue
//   wr_en      one-cycle write strobe
//   tx_status  sender busy flag (1 = busy)
//   tx_data    byte presented to the sender, stable for the whole frame
//   tx_en      launch request to the sender
//   full       FIFO holds DEPTH bytes
//   empty      FIFO holds no bytes
//   count      FIFO occupancy, 0..DEPTH
//   overflow   sticky flag: a write was dropped
//   busy       a byte is being sent or the FIFO holds bytes

module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int AW           = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic          uart_clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          tx_status,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [2:0] {
        SETTLE,
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        RETRY,
        WAIT_DONE,
        GAP
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [7:0]    TMO      = 8'(BUSY_TIMEOUT);

    state_t        state, state_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [7:0]    tmo_cnt, tmo_cnt_nxt;
    logic          gap_cnt, gap_cnt_nxt;
    logic          tx_en_nxt;
    logic [7:0]    tx_data_nxt;
    logic          pop, push;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push  = wr_en && (!full || pop);
    // SETTLE only waits on a frame this block did not launch, so it is not busy.
    assign busy  = !empty || (state != IDLE && state != SETTLE);

    always_ff @(posedge uart_clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (wr_en && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge uart_clk or negedge reset) begin
        if (!reset) begin
            state   <= SETTLE;
            tx_en   <= 1'b0;
            tx_data <= 8'h00;
            tmo_cnt <= '0;
            gap_cnt <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_en   <= tx_en_nxt;
            tx_data <= tx_data_nxt;
            tmo_cnt <= tmo_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tx_en_nxt   = tx_en;
        tx_data_nxt = tx_data;
        tmo_cnt_nxt = tmo_cnt;
        gap_cnt_nxt = gap_cnt;
        pop         = 1'b0;
        case (state)
            SETTLE: begin
                if (!tx_status) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!empty) begin
                    pop         = 1'b1;
                    tx_data_nxt = mem[rd_ptr];
                    state_nxt   = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_en_nxt   = 1'b1;
                tmo_cnt_nxt = '0;
                state_nxt   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tmo_cnt_nxt = tmo_cnt + 8'd1;
                if (tx_status) begin
                    tx_en_nxt = 1'b0;
                    state_nxt = WAIT_DONE;
                end else if (tmo_cnt_nxt == TMO) begin
                    // tx_data is left alone so the same byte is relaunched.
                    tx_en_nxt = 1'b0;
                    state_nxt = RETRY;
                end
            end
            RETRY: begin
                // Together with the LAUNCH cycle this gives two low cycles.
                state_nxt = LAUNCH;
            end
            WAIT_DONE: begin
                if (!tx_status) begin
                    gap_cnt_nxt = 1'b0;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt) begin
                    state_nxt = IDLE;
                end else begin
                    gap_cnt_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = SETTLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural sender stub, an event-time model of
// the feeder checked every cycle, and directed scenarios with literal checks.

module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TMO   = 15;

    logic        uart_clk  = 1'b0;
    logic        reset     = 1'b0;
    logic [7:0]  wr_data   = 8'h00;
    logic        wr_en     = 1'b0;
    logic        tx_status = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW), .BUSY_TIMEOUT(TMO)) dut (
        .uart_clk (uart_clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .tx_status(tx_status),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sender stub (no reset, like the real sender). smode 0: normal frames,
    // 1: forced busy, 2: tied idle. A normal frame raises tx_status so that
    // tx_en is seen high for 3 cycles, then stays busy for 10 bit times.
    int          smode = 0;
    int          scnt  = 0;
    logic [7:0]  sent[$];
    always @(posedge uart_clk) begin
        if (smode == 1) begin
            tx_status <= 1'b1;
            scnt      <= 0;
        end else if (smode == 2) begin
            tx_status <= 1'b0;
            scnt      <= 0;
        end else if (scnt == 0) begin
            tx_status <= 1'b0;
            if (tx_en) scnt <= 1;
        end else if (scnt == 1) begin
            tx_status <= 1'b1;
            scnt      <= 2;
            sent.push_back(tx_data);
        end else if (scnt == 11) begin
            tx_status <= 1'b0;
            scnt      <= 0;
        end else begin
            scnt <= scnt + 1;
        end
    end

    // Serial line as the sender would drive it, sampling tx_data live.
    bit         rec_txd = 0;
    int         txd_n   = 0;
    logic [9:0] txd_vec = '0;
    always @(negedge uart_clk) begin
        if (rec_txd && scnt >= 2 && txd_n < 10) begin
            if (scnt == 2)       txd_vec[txd_n] = 1'b0;
            else if (scnt == 11) txd_vec[txd_n] = 1'b1;
            else                 txd_vec[txd_n] = ((tx_data >> (scnt - 3)) & 8'd1) != 8'd0;
            txd_n++;
        end
    end

    int   en_pulses = 0;
    logic prev_en   = 1'b0;
    always @(negedge uart_clk) begin
        if (tx_en && !prev_en) en_pulses++;
        prev_en = tx_en;
    end

    // Model: timing expressed as edge numbers. After a pop at edge e tx_en
    // rises at e+1; it falls at the first later edge that sees tx_status high,
    // or TMO edges after rising (relaunch two edges later). Once the sender is
    // seen idle again at edge f, the next pop may happen at edge f+3.
    int         cyc        = 0;
    logic [7:0] q[$];
    logic [7:0] m_data     = 8'h00;
    bit         m_en       = 0;
    bit         m_ovf      = 0;
    bit         m_settled  = 0;
    bit         m_inflight = 0;
    int         m_phase    = 0;
    int         m_launch   = 0;
    int         m_idle_at  = 0;

    initial begin
        bit st;
        bit do_pop;
        forever begin
            @(posedge uart_clk or negedge reset);
            if (!reset) begin
                q.delete();
                m_data = 8'h00; m_en = 0; m_ovf = 0; m_settled = 0;
                m_inflight = 0; m_phase = 0; m_launch = 0; m_idle_at = 0; cyc = 0;
            end else begin
                cyc++;
                st     = tx_status;
                do_pop = m_settled && !m_inflight && cyc >= m_idle_at && q.size() > 0;
                if (!m_settled) begin
                    if (!st) begin
                        m_settled = 1;
                        m_idle_at = cyc + 1;
                    end
                end else if (m_inflight) begin
                    case (m_phase)
                        0: if (cyc == m_launch) begin m_en = 1; m_phase = 1; end
                        1: if (st) begin
                               m_en = 0; m_phase = 2;
                           end else if (cyc - m_launch == TMO) begin
                               m_en = 0; m_phase = 0; m_launch = cyc + 2;
                           end
                        default: if (!st) begin m_inflight = 0; m_idle_at = cyc + 3; end
                    endcase
                end
                if (do_pop) begin
                    m_data     = q.pop_front();
                    m_inflight = 1;
                    m_phase    = 0;
                    m_launch   = cyc + 1;
                end
                if (wr_en) begin
                    if (q.size() < DEPTH) q.push_back(wr_data);
                    else                  m_ovf = 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge uart_clk);
            chk("cyc_tx_en",    int'(tx_en),    int'(m_en));
            chk("cyc_tx_data",  int'(tx_data),  int'(m_data));
            chk("cyc_count",    int'(count),    q.size());
            chk("cyc_empty",    int'(empty),    int'(q.size() == 0));
            chk("cyc_full",     int'(full),     int'(q.size() == DEPTH));
            chk("cyc_overflow", int'(overflow), int'(m_ovf));
            chk("cyc_busy",     int'(busy),
                int'(q.size() > 0 || m_inflight || (m_settled && cyc < m_idle_at - 1)));
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge uart_clk);
        reset = 1'b1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge uart_clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while ((busy || tx_status || tx_en) && n < max) begin
            @(negedge uart_clk);
            n++;
        end
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, max);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx_data"},  int'(tx_data),  0);
        chk({tag, "_tx_en"},    int'(tx_en),    0);
        chk({tag, "_full"},     int'(full),     0);
        chk({tag, "_empty"},    int'(empty),    1);
        chk({tag, "_count"},    int'(count),    0);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_busy"},     int'(busy),     0);
    endtask

    initial begin
        int p0, sz0, n, hi, lo;
        bit saw_en, saw_aa;

        // Single byte: latency, frame contents on the line, FIFO drains.
        smode = 0;
        do_reset();
        chk_reset_vals("rst");
        repeat (2) @(negedge uart_clk);
        sent.delete();
        rec_txd = 1;
        wr(8'h55);
        chk("single_count_after_wr", int'(count), 1);
        chk("single_en_n0", int'(tx_en), 0);
        @(negedge uart_clk);
        chk("single_en_n1", int'(tx_en), 0);
        chk("single_data_n1", int'(tx_data), 8'h55);
        @(negedge uart_clk);
        chk("single_en_n2", int'(tx_en), 1);
        wait_idle("single_idle", 100);
        rec_txd = 0;
        chk("single_txd", int'(txd_vec), 10'b1010101010);
        chk("single_sent_n", sent.size(), 1);
        if (sent.size() > 0) chk("single_sent_byte", int'(sent[0]), 8'h55);
        chk("single_count_end", int'(count), 0);

        // Burst of 16 while the sender is held busy, then drain in order.
        smode = 1;
        do_reset();
        sent.delete();
        for (int i = 1; i <= 16; i++) wr(8'(i));
        chk("burst_full", int'(full), 1);
        chk("burst_count", int'(count), 16);
        p0 = en_pulses;
        smode = 0;
        wait_idle("burst_idle", 800);
        chk("burst_pulses", en_pulses - p0, 16);
        chk("burst_sent_n", sent.size(), 16);
        for (int i = 0; i < sent.size() && i < 16; i++) chk("burst_order", int'(sent[i]), i + 1);
        chk("burst_overflow", int'(overflow), 0);

        // Overflow: 17th write while full and no pop is dropped.
        smode = 1;
        do_reset();
        sent.delete();
        for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
        wr(8'hAA);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        smode = 0;
        wait_idle("ovf_idle", 800);
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_sent_n", sent.size(), 16);
        saw_aa = 0;
        foreach (sent[i]) if (sent[i] == 8'hAA) saw_aa = 1;
        chk("ovf_aa_never_sent", int'(saw_aa), 0);

        // Full with a pop in the same cycle: the write is kept, sent last.
        smode = 1;
        do_reset();
        sent.delete();
        for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
        chk("fullpop_full", int'(full), 1);
        smode = 0;
        repeat (2) @(negedge uart_clk);
        wr(8'h77);
        chk("fullpop_count", int'(count), 16);
        chk("fullpop_overflow", int'(overflow), 0);
        wait_idle("fullpop_idle", 900);
        chk("fullpop_sent_n", sent.size(), 17);
        if (sent.size() == 17) begin
            chk("fullpop_first", int'(sent[0]), 8'h40);
            chk("fullpop_last", int'(sent[16]), 8'h77);
        end

        // Timeout retry: sender never goes busy.
        smode = 2;
        do_reset();
        repeat (2) @(negedge uart_clk);
        wr(8'h3C);
        n = 0;
        while (!tx_en && n < 20) begin @(negedge uart_clk); n++; end
        chk("tmo_launch_seen", int'(tx_en), 1);
        hi = 0;
        while (tx_en && hi < 100) begin @(negedge uart_clk); hi++; end
        chk("tmo_high_cycles", hi, 15);
        lo = 0;
        while (!tx_en && lo < 100) begin @(negedge uart_clk); lo++; end
        chk("tmo_low_cycles", lo, 2);
        chk("tmo_data", int'(tx_data), 8'h3C);
        chk("tmo_count", int'(count), 0);

        // Reset mid-frame with bytes queued; SETTLE waits for the old frame.
        smode = 0;
        do_reset();
        repeat (2) @(negedge uart_clk);
        sent.delete();
        wr(8'hA1); wr(8'hA2); wr(8'hA3); wr(8'hA4);
        n = 0;
        while (!tx_status && n < 20) begin @(negedge uart_clk); n++; end
        chk("mid_frame_started", int'(tx_status), 1);
        @(negedge uart_clk);
        sz0 = sent.size();
        #2 reset = 1'b0;
        #1 chk_reset_vals("midrst");
        @(negedge uart_clk);
        reset = 1'b1;
        chk("mid_status_still_busy", int'(tx_status), 1);
        wr(8'h99);
        saw_en = 0;
        n = 0;
        while (tx_status && n < 30) begin
            if (tx_en) saw_en = 1;
            @(negedge uart_clk);
            n++;
        end
        chk("mid_no_en_while_busy", int'(saw_en), 0);
        wait_idle("mid_idle", 100);
        chk("mid_sent_n", sent.size(), sz0 + 1);
        if (sent.size() > 0) chk("mid_sent_last", int'(sent[sent.size() - 1]), 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
